// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

    // Arbiter control state: either nobody holds the resource or one requester does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_arb_state_t;

    // Widest requester vector the helpers below accept.
    localparam int unsigned RR_ARB_MAX_ISIZE = 32;

    // Binary index of the set bit of a one-hot (or all-zero) vector.
    // Returns 0 for an all-zero input.
    function automatic int unsigned onehot_to_idx(input logic [RR_ARB_MAX_ISIZE-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < RR_ARB_MAX_ISIZE; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
    parameter int ISIZE = 8
) ();
    localparam int IW = $clog2(ISIZE);

    logic [ISIZE-1:0] reqs;
    logic             ack;
    logic [ISIZE-1:0] gnts;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;
    logic             timeout;

    modport master (
        output reqs,
        output ack,
        input  gnts,
        input  gnt_valid,
        input  gnt_idx,
        input  timeout
    );

    modport slave (
        input  reqs,
        input  ack,
        output gnts,
        output gnt_valid,
        output gnt_idx,
        output timeout
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
// Searches reqs_i upward from bit ptr_i, wrapping past the top bit to 0;
// the first set bit wins. Implemented by duplicating the request vector,
// masking everything below ptr_i and taking the lowest remaining bit.
module rr_pick #(
    parameter int ISIZE = 8
) (
    input  logic [ISIZE-1:0]         reqs_i,
    input  logic [$clog2(ISIZE)-1:0] ptr_i,
    output logic [ISIZE-1:0]         pick_o,
    output logic                     found_o
);
    localparam int DW = 2 * ISIZE;

    logic [DW-1:0] mask;
    logic [DW-1:0] dbl_reqs;

    // Lowest set bit of the masked double-width vector, folded back to ISIZE.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick_o   = '0;
        mask     = {DW{1'b1}} << ptr_i;
        dbl_reqs = {reqs_i, reqs_i} & mask;
        for (int j = DW - 1; j >= 0; j--) begin
            if (dbl_reqs[j]) begin
                pick_o              = '0;
                pick_o[j % ISIZE]   = 1'b1;
            end
        end
        // The upper copy is never masked, so any request guarantees a pick.
        found_o = |reqs_i;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter with grant hold.
// A grant stays put until the holder acks, withdraws its request or (with
// RR_ARB_TIMEOUT_EN defined) exceeds MAX_HOLD cycles. Priority then rotates
// to the bit after the former holder.
// Optional feature macro: RR_ARB_TIMEOUT_EN (hold-limit counter and timeout).
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int ISIZE    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter_if.slave  bus
);
    localparam int PW = $clog2(ISIZE);

    // Out-of-range parameters are rejected at elaboration.
    if (ISIZE < 2 || ISIZE > RR_ARB_MAX_ISIZE || MAX_HOLD < 2) begin : g_bad_params
        $error("rr_arbiter: ISIZE must be 2..32 and MAX_HOLD must be >= 2");
    end

    rr_arb_state_t    state_q;
    logic [PW-1:0]    ptr_q;
    logic [ISIZE-1:0] gnts_q;
    logic             gnt_valid_q;
    logic [PW-1:0]    gnt_idx_q;

    logic             withdraw;
    logic             hold_expire;
    logic             timeout_c;
    logic             release_c;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_d;
    logic [ISIZE-1:0] pick_d;
    logic             found_d;
    logic [PW-1:0]    gnt_idx_d;

    // Release conditions for the current holder.
    assign withdraw  = ~bus.reqs[gnt_idx_q];
    assign timeout_c = (state_q == GRANT) && hold_expire && !bus.ack && !withdraw;
    assign release_c = (state_q == GRANT) && (bus.ack || withdraw || timeout_c);

    // On release the former holder drops to lowest priority; the picker sees
    // the rotated pointer in the same cycle so the next grant has no bubble.
    assign ptr_inc = (gnt_idx_q == PW'(ISIZE - 1)) ? '0 : gnt_idx_q + PW'(1);
    assign ptr_d   = release_c ? ptr_inc : ptr_q;

    rr_pick #(
        .ISIZE (ISIZE)
    ) u_pick (
        .reqs_i  (bus.reqs),
        .ptr_i   (ptr_d),
        .pick_o  (pick_d),
        .found_o (found_d)
    );

    assign gnt_idx_d = PW'(onehot_to_idx(RR_ARB_MAX_ISIZE'(pick_d)));

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);

    logic [CW-1:0] hold_cnt_q;

    assign hold_expire = (hold_cnt_q == CW'(MAX_HOLD - 1));

    // Hold counter: zero outside GRANT and on every handover, counts held cycles otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
        end else if (state_q == IDLE || release_c) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
        end
    end
`else
    assign hold_expire = 1'b0;
`endif

    // Arbitration FSM with registered grant outputs and priority pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: synchronous reset covers every control register; there is no storage array to leave unreset.
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnts_q      <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        gnts_q      <= pick_d;
                        gnt_valid_q <= 1'b1;
                        gnt_idx_q   <= gnt_idx_d;
                        state_q     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        ptr_q <= ptr_d;
                        if (found_d) begin
                            gnts_q      <= pick_d;
                            gnt_valid_q <= 1'b1;
                            gnt_idx_q   <= gnt_idx_d;
                        end else begin
                            gnts_q      <= '0;
                            gnt_valid_q <= 1'b0;
                            gnt_idx_q   <= '0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnts      = gnts_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.timeout   = timeout_c;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: self-checking bench for rr_arbiter (ISIZE=8, MAX_HOLD=4).
// A behavioural reference model predicts the registered outputs; expectations
// are queued when stimulus is driven and compared after the clock edge.
// Honours RR_ARB_TIMEOUT_EN the same way the design does.
module tb_rr_arbiter;
    localparam int ISIZE    = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rr_arbiter_if #(.ISIZE(ISIZE)) bus ();

    rr_arbiter #(
        .ISIZE    (ISIZE),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] gnts;
        logic       valid;
        logic [2:0] idx;
    } exp_t;

    exp_t sb_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit m_busy = 1'b0;
    int m_ptr  = 0;
    int m_idx  = 0;
    int m_cnt  = 0;

    logic [7:0] g;
    logic       t;

    logic [7:0] exp_1f [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h01};
    logic [7:0] exp_3a [4] = '{8'h20, 8'h02, 8'h08, 8'h10};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Linear wrap-around scan from p; -1 when nothing is requested.
    function automatic int search(input logic [7:0] r, input int p);
        for (int k = 0; k < ISIZE; k++) begin
            if (r[(p + k) % ISIZE]) return (p + k) % ISIZE;
        end
        return -1;
    endfunction

    function automatic bit model_timeout(input logic [7:0] r, input logic a);
`ifdef RR_ARB_TIMEOUT_EN
        return m_busy && (m_cnt == MAX_HOLD - 1) && !a && r[m_idx];
`else
        return 1'b0 & r[0] & a;
`endif
    endfunction

    // One clock of stimulus: drive at negedge, check timeout, predict, check after posedge.
    task automatic step(input logic [7:0] r, input logic a, input logic rs,
                        output logic [7:0] g_o, output logic t_o);
        exp_t e;
        bit   to;
        bit   rel;
        int   k;
        @(negedge clk);
        rst      = rs;
        bus.reqs = r;
        bus.ack  = a;
        #1;
        to  = model_timeout(r, a);
        t_o = bus.timeout;
        check("timeout", 32'(bus.timeout), 32'(to));

        if (rs) begin
            m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_cnt = 0;
        end else if (!m_busy) begin
            k = search(r, m_ptr);
            if (k >= 0) begin
                m_busy = 1'b1; m_idx = k; m_cnt = 0;
            end
        end else begin
            rel = a || !r[m_idx] || to;
            if (rel) begin
                m_ptr = (m_idx + 1) % ISIZE;
                k = search(r, m_ptr);
                if (k >= 0) begin
                    m_idx = k; m_cnt = 0;
                end else begin
                    m_busy = 1'b0; m_idx = 0; m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        e.gnts  = m_busy ? 8'(1 << m_idx) : 8'h00;
        e.valid = m_busy;
        e.idx   = 3'(m_idx);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("gnts",      32'(bus.gnts),      32'(e.gnts));
            check("gnt_valid", 32'(bus.gnt_valid), 32'(e.valid));
            check("gnt_idx",   32'(bus.gnt_idx),   32'(e.idx));
            check("onehot0",   32'($onehot0(bus.gnts)), 32'd1);
        end
        g_o = bus.gnts;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       a;
        logic       rs;

        rst      = 1'b1;
        bus.reqs = '0;
        bus.ack  = 1'b0;

        // Reset, then idle with no requests.
        step(8'h00, 1'b0, 1'b1, g, t);
        step(8'h00, 1'b0, 1'b1, g, t);
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b0, 1'b0, g, t);
            check("rst_idle", 32'(g), 32'h0);
        end

        // Full rotation with ack on every grant, wrapping back to bit 0.
        for (int i = 0; i < 6; i++) begin
            step(8'h1F, 1'b1, 1'b0, g, t);
            check("rr_1f", 32'(g), 32'(exp_1f[i]));
        end

        // Rotate to bit 4, then wrap-around ordering from ptr=5.
        step(8'h00, 1'b0, 1'b1, g, t);
        for (int i = 0; i < 5; i++) begin
            step(8'h1F, 1'b1, 1'b0, g, t);
        end
        check("pre_3a", 32'(g), 32'h10);
        for (int i = 0; i < 4; i++) begin
            step(8'h3A, 1'b1, 1'b0, g, t);
            check("rr_3a", 32'(g), 32'(exp_3a[i]));
        end

        // Hold without ack, then the holder withdraws.
        step(8'h00, 1'b0, 1'b1, g, t);
        for (int i = 0; i < 4; i++) begin
            step(8'h0A, 1'b0, 1'b0, g, t);
            check("hold_02", 32'(g), 32'h02);
        end
        step(8'h08, 1'b0, 1'b0, g, t);
        check("withdraw_gnt", 32'(g), 32'h08);
        check("withdraw_idx", 32'(bus.gnt_idx), 32'd3);

        // Hold limit (or indefinite hold without the feature).
        step(8'h00, 1'b0, 1'b1, g, t);
        for (int i = 0; i < 8; i++) begin
            step(8'h06, 1'b0, 1'b0, g, t);
`ifdef RR_ARB_TIMEOUT_EN
            check("to_flag", 32'(t), 32'(i == 4));
            check("to_gnt",  32'(g), (i < 4) ? 32'h02 : 32'h04);
`else
            check("to_flag", 32'(t), 32'd0);
            check("to_gnt",  32'(g), 32'h02);
`endif
        end

        // Reset in the middle of a grant restores ptr=0.
        step(8'h00, 1'b0, 1'b1, g, t);
        step(8'h04, 1'b0, 1'b0, g, t);
        check("mid_gnt", 32'(g), 32'h04);
        step(8'h04, 1'b0, 1'b0, g, t);
        step(8'h04, 1'b1, 1'b1, g, t);
        check("mid_rst", 32'(g), 32'h0);
        step(8'h14, 1'b0, 1'b0, g, t);
        check("post_rst", 32'(g), 32'h04);

        // Ack while idle is ignored.
        step(8'h00, 1'b1, 1'b0, g, t);
        step(8'h00, 1'b1, 1'b0, g, t);
        check("idle_ack", 32'(g), 32'h0);
        step(8'h80, 1'b1, 1'b0, g, t);
        check("idle_ack_gnt", 32'(g), 32'h80);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'h00;
            else if ($urandom_range(0, 2) == 0) r = 8'(1 << $urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 59) == 0);
            step(r, a, rs, g, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
